nios_mul_cell_seq: RTL

- Issuing and consuming end of the Nios II 16x16 multiplier-cell interface.
- Accepts 32x32 multiply requests over a valid/ready handshake and drives the cell operands and enable.
- Captures the three 16x16 partial products (lo*lo, lo*hi, hi*lo) and assembles the low 32 bits of the product.
- Returns the result with its destination tag over a valid/ready handshake. Used by the custom-instruction and coprocessor path that shares the multiplier cell.

---
 rtl/nios_mul_pkg.sv | 27 ++
 rtl/nios_mul_cell_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios II multiplier-cell sequencer.
// The state type, datapath widths and partial-product assembly live here.
package nios_mul_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int HALF_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SUM,
        RESP
    } mul_state_e;

    // Low 32 bits of A*B from the three 16x16 partial products.
    // p2+p3 needs 33 bits. Anything shifted above bit 31 is dropped,
    // because only the low word of the product is kept.
    function automatic logic [MUL_DATA_W-1:0] mul_assemble(
        input logic [MUL_DATA_W-1:0] p1,
        input logic [MUL_DATA_W-1:0] p2,
        input logic [MUL_DATA_W-1:0] p3
    );
        return MUL_DATA_W'(p1 + (({1'b0, p2} + {1'b0, p3}) << HALF_W));
    endfunction

endpackage

// File: rtl/nios_mul_cell_seq.sv
// Issues 32x32 multiply requests to the shared 16x16 multiplier cell.
// It then assembles the low product word and returns it with its tag.
module nios_mul_cell_seq
    import nios_mul_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int CELL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MUL_DATA_W-1:0] req_src1,
    input  logic [MUL_DATA_W-1:0] req_src2,
    input  logic [TAG_W-1:0]      req_tag,
    output logic [MUL_DATA_W-1:0] cell_src1,
    output logic [MUL_DATA_W-1:0] cell_src2,
    output logic                  cell_en,
    input  logic [MUL_DATA_W-1:0] cell_p1,
    input  logic [MUL_DATA_W-1:0] cell_p2,
    input  logic [MUL_DATA_W-1:0] cell_p3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MUL_DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy
);

    localparam int CNT_W = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

    mul_state_e        state;
    mul_state_e        state_next;
    logic              accept;
    logic [TAG_W-1:0]  held_tag;
    logic [CNT_W-1:0]  wait_cnt;

    assign cell_en   = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Next-state and request acceptance. Flush overrides every handshake.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (CELL_LAT > 1) begin
                    state_next = WAIT;
                end else begin
                    state_next = SUM;
                end
            end
            WAIT: begin
                if (int'(wait_cnt) >= CELL_LAT - 2) begin
                    state_next = SUM;
                end
            end
            SUM: begin
                state_next = RESP;
            end
            RESP: begin
                req_ready = rsp_ready && !flush;
                if (rsp_ready) begin
                    state_next = req_valid ? ISSUE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
        accept = req_valid && req_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, cell-latency counter and result registration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_src1  <= '0;
            cell_src2  <= '0;
            held_tag   <= '0;
            wait_cnt   <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else begin
            if (accept) begin
                cell_src1 <= req_src1;
                cell_src2 <= req_src2;
                held_tag  <= req_tag;
            end
            if (state == ISSUE || flush) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == SUM && !flush) begin
                rsp_result <= mul_assemble(cell_p1, cell_p2, cell_p3);
                rsp_tag    <= held_tag;
            end
        end
    end

endmodule
